// File: rtl/cifrador_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cifrador_pkg
//  Description : Shared definitions for the 8-bit toy block cipher: default
//                round count and rotate amount, round-constant and rotate
//                helpers, FSM state encoding and mode encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package cifrador_pkg;

    // Default number of rounds (legal 1..8) and rotate amount (legal 1..7)
    localparam int ROUNDS_DEF = 4;
    localparam int ROT_DEF    = 3;

    // Operation mode encoding
    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    // Control FSM states
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Round constant: a single walking one selected by the round index
    function automatic logic [7:0] rc(input logic [2:0] r);
        return 8'h01 << r;
    endfunction

    // 8-bit rotate left; the right shift by 8 for n=0 yields zero, so n=0 is identity
    function automatic logic [7:0] rotl8(input logic [7:0] v, input logic [2:0] n);
        return (v << n) | (v >> (4'd8 - {1'b0, n}));
    endfunction

    // 8-bit rotate right, inverse of rotl8 for the same amount
    function automatic logic [7:0] rotr8(input logic [7:0] v, input logic [2:0] n);
        return (v >> n) | (v << (4'd8 - {1'b0, n}));
    endfunction

endpackage
`default_nettype wire

// File: rtl/cifrador_round.sv
`default_nettype none
// ============================================================================
//  Module      : cifrador_round
//  Description : One combinational cipher round. Encrypt mixes the round key
//                in and then rotates left; decrypt undoes that by rotating
//                right and then mixing the same round key back out.
//  Revision    : 1.0 - initial release
// ============================================================================
module cifrador_round
    import cifrador_pkg::*;
#(
    parameter int ROT = ROT_DEF
) (
    input  logic [7:0] x,
    input  logic [7:0] k,
    input  logic       mode,
    output logic [7:0] x_next
);

    localparam logic [2:0] C_ROT = 3'(ROT);

    // Forward round for encrypt, inverse round for decrypt
    always_comb begin
        x_next = 8'h00;
        if (mode == MODE_DEC) begin
            x_next = rotr8(x, C_ROT) ^ k;
        end else begin
            x_next = rotl8(x ^ k, C_ROT);
        end
    end

endmodule
`default_nettype wire

// File: rtl/cifrador_8bits.sv
`default_nettype none
// ============================================================================
//  Module      : cifrador_8bits
//  Description : Tiny Tapeout user block - iterative 8-bit toy block cipher
//                with a loadable key, one round per clock. A start latches
//                the data byte and mode; after ROUNDS edges the result is
//                registered on uo_out together with a one-cycle done pulse.
//                Optional macro CIFRADOR_PARITY_EN drives the even parity of
//                uo_out on uio_out[5] and enables that pin as an output.
//  Revision    : 1.0 - initial release
// ============================================================================
module cifrador_8bits
    import cifrador_pkg::*;
#(
    parameter int ROUNDS = ROUNDS_DEF,
    parameter int ROT    = ROT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,     // active-high synchronous reset despite its name
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [2:0] C_LAST = 3'(ROUNDS - 1);

    state_t     r_state;
    logic [7:0] r_key;
    logic [7:0] r_x;
    logic [2:0] r_cnt;
    logic       r_mode;
    logic [7:0] r_result;
    logic       r_busy;
    logic       r_done;

    logic       w_start;
    logic       w_mode;
    logic       w_load_key;
    logic [2:0] w_round_idx;
    logic [7:0] w_round_key;
    logic [7:0] w_x_next;
    logic       w_parity;
    logic       w_unused_ok;

    assign w_start    = uio_in[0];
    assign w_mode     = uio_in[1];
    assign w_load_key = uio_in[2];

    // The enable and upper bidirectional inputs carry no function here
    assign w_unused_ok = &{1'b0, ena, uio_in[7:3]};

    // Decrypt walks the round keys in reverse order
    assign w_round_idx = (r_mode == MODE_DEC) ? (C_LAST - r_cnt) : r_cnt;
    assign w_round_key = r_key ^ rc(w_round_idx);

    cifrador_round #(
        .ROT    (ROT)
    ) u_round (
        .x      (r_x),
        .k      (w_round_key),
        .mode   (r_mode),
        .x_next (w_x_next)
    );

    // Control FSM: key load / start in IDLE, one round per edge in RUN
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state  <= IDLE;
            r_key    <= 8'h00;
            r_x      <= 8'h00;
            r_cnt    <= 3'd0;
            r_mode   <= MODE_ENC;
            r_result <= 8'h00;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_load_key) begin
                        r_key <= ui_in;
                    end else if (w_start) begin
                        r_x     <= ui_in;
                        r_mode  <= w_mode;
                        r_cnt   <= 3'd0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_x <= w_x_next;
                    if (r_cnt == C_LAST) begin
                        r_result <= w_x_next;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef CIFRADOR_PARITY_EN
    assign w_parity = ^r_result;
    assign uio_oe   = 8'hE0;
`else
    assign w_parity = 1'b0;
    assign uio_oe   = 8'hC0;
`endif

    assign uo_out  = r_result;
    assign uio_out = {r_done, r_busy, w_parity, 5'b00000};

endmodule
`default_nettype wire

// File: tb/tb_cifrador_8bits.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cifrador_8bits
//  Description : Self-checking bench for cifrador_8bits. Stimulus pushes the
//                hand-computed result into a queue; a monitor pops and
//                compares whenever done is presented.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cifrador_8bits;

    localparam int ROUNDS = 4;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int         n_checks;
    int         n_errors;
    logic [7:0] exp_q[$];
    logic       prev_done;

`ifdef CIFRADOR_PARITY_EN
    localparam logic [7:0] C_OE = 8'hE0;
    localparam bit         C_PAR_EN = 1'b1;
`else
    localparam logic [7:0] C_OE = 8'hC0;
    localparam bit         C_PAR_EN = 1'b0;
`endif

    cifrador_8bits dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation
    initial prev_done = 1'b0;
    always @(negedge clk) begin
        logic [7:0] e;
        if (uio_out[7] === 1'b1) begin
            chk("done_width", {7'd0, prev_done}, 8'h00);
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 8'h01, 8'h00);
            end else begin
                e = exp_q.pop_front();
                chk("result", uo_out, e);
                chk("parity", {7'd0, uio_out[5]}, {7'd0, C_PAR_EN & (^e)});
            end
        end
        prev_done = (uio_out[7] === 1'b1);
    end

    task automatic load_key(input logic [7:0] k);
        ui_in  = k;
        uio_in = 8'b0000_0100;
        @(posedge clk); #1;
        uio_in = 8'h00;
        ui_in  = 8'h00;
    endtask

    task automatic start_op(input logic m, input logic [7:0] d, input logic [7:0] e, input bit push);
        ui_in  = d;
        uio_in = {5'b00000, 1'b0, m, 1'b1};
        if (push) exp_q.push_back(e);
        @(posedge clk); #1;
        uio_in = 8'h00;
        ui_in  = 8'h00;
    endtask

    // Checks busy for ROUNDS cycles then the done cycle; optionally pokes
    // start and load_key while the operation is in flight.
    task automatic check_run(input bit poke);
        for (int i = 0; i < ROUNDS; i++) begin
            @(negedge clk);
            chk("busy_run", {6'd0, uio_out[7:6]}, 8'h01);
            if (poke && i == 0) begin
                ui_in  = 8'h77;
                uio_in = 8'b0000_0011;
            end else if (poke && i == 1) begin
                ui_in  = 8'h12;
                uio_in = 8'b0000_0100;
            end else begin
                ui_in  = 8'h00;
                uio_in = 8'h00;
            end
        end
        @(negedge clk);
        chk("done_cycle", {6'd0, uio_out[7:6]}, 8'h02);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b1;
        ena      = 1'b1;
        ui_in    = 8'h00;
        uio_in   = 8'h00;

        // Reset
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("reset_uo_out", uo_out, 8'h00);
        chk("reset_uio_out", uio_out, 8'h00);
        chk("reset_uio_oe", uio_oe, C_OE);

        // Key 0x00, encrypt 0x00
        start_op(1'b0, 8'h00, 8'h55, 1'b1);
        check_run(1'b0);

        // Key 0xFF, encrypt 0xFF; done lasts one cycle
        load_key(8'hFF);
        start_op(1'b0, 8'hFF, 8'hAA, 1'b1);
        check_run(1'b0);
        @(negedge clk);
        chk("done_cleared", {7'd0, uio_out[7]}, 8'h00);
        chk("uo_out_hold", uo_out, 8'hAA);

        // Decrypt round trips
        start_op(1'b1, 8'hAA, 8'hFF, 1'b1);
        check_run(1'b0);
        load_key(8'h00);
        start_op(1'b1, 8'h55, 8'h00, 1'b1);
        check_run(1'b0);

        // Ignored start/load_key while busy, then back-to-back with old key
        start_op(1'b0, 8'h00, 8'h55, 1'b1);
        check_run(1'b1);
        start_op(1'b0, 8'h00, 8'h55, 1'b1);
        check_run(1'b0);
        start_op(1'b1, 8'h55, 8'h00, 1'b1);
        check_run(1'b0);

        // Key 0x12
        load_key(8'h12);
        start_op(1'b1, 8'h44, 8'h00, 1'b1);
        check_run(1'b0);
        start_op(1'b0, 8'h00, 8'h44, 1'b1);
        check_run(1'b0);

        // Reset in the middle of an operation
        load_key(8'h34);
        start_op(1'b0, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("abort_uo_out", uo_out, 8'h00);
        chk("abort_uio_out", uio_out, 8'h00);
        repeat (ROUNDS + 2) @(negedge clk);
        chk("abort_no_done", {7'd0, uio_out[7]}, 8'h00);

        // Key must be back to zero after reset
        start_op(1'b0, 8'h00, 8'h55, 1'b1);
        check_run(1'b0);

        repeat (3) @(negedge clk);
        chk("queue_empty", 8'(exp_q.size()), 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
